// File: rtl/apb_arbiter_if.sv
// apb_arbiter_if: requester-side request/ack bundle plus APB master port of the arbiter.
interface apb_arbiter_if #(
    parameter int NM = 2,
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [NM-1:0]        i_req;
    logic [NM*AW-1:0]     i_addr;
    logic [NM-1:0]        i_write;
    logic [NM*DW-1:0]     i_wdata;
    logic [NM*DW/8-1:0]   i_wstrb;
    logic [NM*3-1:0]      i_prot;
    logic [NM-1:0]        o_ack;
    logic [DW-1:0]        o_rdata;
    logic                 o_err;
    logic                 PSEL;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [AW-1:0]        PADDR;
    logic [DW-1:0]        PWDATA;
    logic [DW/8-1:0]      PWSTRB;
    logic [2:0]           PPROT;
    logic                 PREADY;
    logic [DW-1:0]        PRDATA;
    logic                 PSLVERR;

    modport master (
        input  i_req, i_addr, i_write, i_wdata, i_wstrb, i_prot, PREADY, PRDATA, PSLVERR,
        output o_ack, o_rdata, o_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PWSTRB, PPROT
    );

    modport slave (
        output i_req, i_addr, i_write, i_wdata, i_wstrb, i_prot, PREADY, PRDATA, PSLVERR,
        input  o_ack, o_rdata, o_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PWSTRB, PPROT
    );
endinterface

// File: rtl/apb_arbiter.sv
// apb_arbiter: round-robin arbiter of NM request/ack clients onto one APB master port.
// Define APB_ARBITER_B2B_EN to chain the next grant straight from ACCESS without an idle cycle.
module apb_arbiter #(
    parameter int NM = 2,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          PCLK,
    input  logic          PRESET,
    apb_arbiter_if.master bus
);
    localparam int PW = NM > 1 ? $clog2(NM) : 1;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0]      state;
    logic [PW-1:0]   ptr, g, base, nxt;
    logic [NM-1:0]   elig, elig_nxt;
    logic            go, load;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [DW/8-1:0] sel_wstrb;
    logic [2:0]      sel_prot;
    logic            sel_write;

    // First set bit of e scanning upward from b+1, wrapping at NM.
    function automatic logic [PW-1:0] pick(input logic [NM-1:0] e, input logic [PW-1:0] b);
        int idx;
        pick = b;
        for (int k = NM; k >= 1; k--) begin
            idx = (int'(b) + k) % NM;
            if (e[idx]) pick = PW'(idx);
        end
    endfunction

    always_comb begin
        elig      = bus.i_req & ~bus.o_ack;
        base      = state == ACCESS ? g : ptr;
        elig_nxt  = state == ACCESS ? elig & ~(NM'(1) << g) : elig;
        go        = |elig_nxt;
        nxt       = pick(elig_nxt, base);
        sel_addr  = bus.i_addr[nxt*AW +: AW];
        sel_wdata = bus.i_wdata[nxt*DW +: DW];
        sel_wstrb = bus.i_wstrb[nxt*(DW/8) +: DW/8];
        sel_prot  = bus.i_prot[nxt*3 +: 3];
        sel_write = bus.i_write[nxt];
`ifdef APB_ARBITER_B2B_EN
        load      = go && (state == IDLE || (state == ACCESS && bus.PREADY));
`else
        load      = go && state == IDLE;
`endif
    end

    // Later assignments win: a new grant overrides the return to IDLE on completion.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state       <= IDLE;
            ptr         <= PW'(NM - 1);
            g           <= '0;
            bus.PSEL    <= 1'b0;
            bus.PENABLE <= 1'b0;
            bus.PWRITE  <= 1'b0;
            bus.PADDR   <= '0;
            bus.PWDATA  <= '0;
            bus.PWSTRB  <= '0;
            bus.PPROT   <= '0;
            bus.o_ack   <= '0;
            bus.o_rdata <= '0;
            bus.o_err   <= 1'b0;
        end else begin
            bus.o_ack <= '0;
            if (state == SETUP) begin
                bus.PENABLE <= 1'b1;
                state       <= ACCESS;
            end
            if (state == ACCESS && bus.PREADY) begin
                bus.o_ack   <= NM'(1) << g;
                bus.o_rdata <= bus.PWRITE ? '0 : bus.PRDATA;
                bus.o_err   <= bus.PSLVERR;
                ptr         <= g;
                bus.PSEL    <= 1'b0;
                bus.PENABLE <= 1'b0;
                state       <= IDLE;
            end
            if (load) begin
                g           <= nxt;
                bus.PSEL    <= 1'b1;
                bus.PENABLE <= 1'b0;
                bus.PWRITE  <= sel_write;
                bus.PADDR   <= sel_addr;
                bus.PWDATA  <= sel_wdata;
                bus.PWSTRB  <= sel_write ? sel_wstrb : '0;
                bus.PPROT   <= sel_prot;
                state       <= SETUP;
            end
        end
    end
endmodule

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
- Multi-requester APB master: NM simple request/acknowledge clients share one APB3/APB4 master port.
- Round-robin arbitration; one transfer at a time; sequences the SETUP/ACCESS phases itself.
- Sits between internal bus bridges and a single APB peripheral bus.
- Its APB port must satisfy the team's APB slave-side formal property set: PSEL/PENABLE sequencing, stable fields while stalled, PWSTRB rules.

Parameters:
- NM, 2: number of requesters (≥1).
- AW, 32: address width.
- DW, 32: data width (multiple of 8).

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  asynchronous, active-high reset.
- i_req  in  NM  per-requester request; held until matching o_ack.
- i_addr  in  NM*AW  per-requester address (requester i at bits [i*AW +: AW]).
- i_write  in  NM  per-requester write flag.
- i_wdata  in  NM*DW  per-requester write data.
- i_wstrb  in  NM*DW/8  per-requester byte strobes.
- i_prot  in  NM*3  per-requester protection.
- o_ack  out  NM  one-cycle completion pulse, one-hot or zero.
- o_rdata  out  DW  read data, valid when any o_ack is set.
- o_err  out  1  PSLVERR of the completed transfer, valid with o_ack.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  AW  APB address.
- PWDATA  out  DW  APB write data.
- PWSTRB  out  DW/8  APB write strobes.
- PPROT  out  3  APB protection.
- PREADY  in  1  APB slave ready.
- PRDATA  in  DW  APB read data.
- PSLVERR  in  1  APB slave error.

Behaviour:
- All outputs are registered.
- Reset, asynchronous and applied at any time including mid-transfer:
  - state=IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, PWSTRB, PPROT, o_ack, o_rdata, o_err all 0.
  - Last-grant pointer = NM-1, so requester 0 wins first.
  - An in-flight transfer is dropped with no o_ack.
- Eligible set = i_req & ~o_ack. A requester being acknowledged this cycle is excluded for this cycle.
- Grant: first eligible index scanning upward from pointer+1 modulo NM.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If the eligible set is empty, stay IDLE.
  - Otherwise latch the granted requester's addr/write/prot/wdata into P* outputs. PWSTRB = i_wstrb if write, else 0.
  - PSEL<=1, PENABLE<=0; go to SETUP.
- SETUP: PENABLE<=1; go to ACCESS.
- ACCESS with PREADY=0: hold all P* outputs unchanged; no timeout.
- ACCESS with PREADY=1:
  - o_ack[g]<=1, o_rdata<=PRDATA (0 on writes), o_err<=PSLVERR.
  - pointer<=g.
  - PSEL<=0, PENABLE<=0; go to IDLE.
- o_ack is forced to 0 on every cycle except the one following PREADY in ACCESS.
- o_rdata and o_err hold their values otherwise.
- Latency with zero wait states:
  - i_req rises in cycle 0.
  - PSEL=1 in cycle 1.
  - PENABLE=1 in cycle 2.
  - o_ack=1 in cycle 3.
  - Each PREADY=0 cycle in ACCESS adds one cycle.
- Requester contract: a requester may re-raise i_req the cycle after o_ack. Changing fields while i_req is held is undefined. Fields are sampled only at grant.
- Simultaneous requests: strict rotation, so no requester waits more than NM-1 transfers.
- Without the optional feature, there is one PSEL=0 cycle between transfers.

Optional Feature:
- Macro: APB_ARBITER_B2B_EN.
- Defined:
  - In ACCESS with PREADY=1, if the eligible set (computed with g also masked) is non-empty, grant the next requester directly.
  - PSEL stays 1, PENABLE<=0, new fields are latched, next state is SETUP.
  - o_ack[g] still pulses the next cycle.
  - Zero-wait back-to-back throughput becomes one transfer per 2 cycles.
- Undefined: always return to IDLE as above, giving 3 cycles per transfer.

Test Plan:
1. Reset, then requester 0 writes addr 0x10, data 0xDEADBEEF, strb 0xF, PREADY=1 -> PSEL cycle 1, PENABLE cycle 2 with PADDR=0x10/PWSTRB=0xF, o_ack=2'b01 in cycle 3, o_err=0.
2. Requester 1 reads 0x24, slave holds PREADY=0 for 3 ACCESS cycles then returns PRDATA=0x12345678, PSLVERR=1 -> P* outputs stable throughout, o_ack=2'b10 with o_rdata=0x12345678, o_err=1; PWSTRB=0 during the read.
3. Both i_req held continuously for 4 transfers -> grant order 0,1,0,1; never two o_ack bits set at once.
4. Assert PRESET during ACCESS -> PSEL=PENABLE=0 immediately (asynchronous); no o_ack; after release, requester 0 is granted first.
5. Requester 0 re-asserts i_req on the cycle after o_ack while requester 1 is idle -> second transfer starts correctly; no duplicate grant on the o_ack cycle.
6. With APB_ARBITER_B2B_EN defined and both requesting, PREADY=1 -> PSEL stays high between transfers; second PENABLE appears 2 cycles after the first; without the macro there is one PSEL=0 gap cycle.
